// File: rtl/lava_decoder_if.sv
// Token-in / sample-out bundle for the LAVA reconstruction stage.
// The slave modport is the decoder's view; master is the upstream/downstream view.
interface lava_decoder_if #(
    parameter int Data_bits   = 10,
    parameter int Index_width = 12
);
    logic [Data_bits+Index_width-1:0] token_i;
    logic                             token_valid_i;
    logic                             frame_done_i;
    logic                             token_ready_o;
    logic [Data_bits-1:0]             sample_o;
    logic [Index_width-1:0]           sample_index_o;
    logic                             sample_valid_o;
    logic                             sample_ready_i;
    logic                             frame_last_o;
    logic                             overflow_o;
    logic                             error_o;

    modport slave (
        input  token_i, token_valid_i, frame_done_i, sample_ready_i,
        output token_ready_o, sample_o, sample_index_o, sample_valid_o,
               frame_last_o, overflow_o, error_o
    );

    modport master (
        output token_i, token_valid_i, frame_done_i, sample_ready_i,
        input  token_ready_o, sample_o, sample_index_o, sample_valid_o,
               frame_last_o, overflow_o, error_o
    );
endinterface

// File: rtl/lava_decoder.sv
// LAVA decoder: buffers sparse {value, index} tokens in a small FIFO and
// rebuilds the dense per-channel sample stream with sample-and-hold.
// Optional feature macro: LAVA_DECODER_ORDER_CHECK_EN (discard tokens whose
// index is behind the output position and raise error_o).
module lava_decoder #(
    parameter int Data_bits           = 10,
    parameter int Samples_per_channel = 3328,
    parameter int Fifo_depth          = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lava_decoder_if.slave bus
);
    localparam int Index_width = $clog2(Samples_per_channel);
    localparam int ptr_width   = $clog2(Fifo_depth);
    localparam int entry_width = Data_bits + Index_width + 2;
    localparam logic [Index_width-1:0] last_index = Index_width'(Samples_per_channel - 1);
    localparam logic [ptr_width:0]     full_count = (ptr_width + 1)'(Fifo_depth);

    typedef enum logic {RUN, FLUSH} state_t;

    // FIFO storage: entry = {last, has_tok, value, index}
    logic [entry_width-1:0] mem [Fifo_depth];
    logic [ptr_width-1:0]   wr_ptr;
    logic [ptr_width-1:0]   rd_ptr;
    logic [ptr_width:0]     count;

    logic full;
    logic empty;
    logic push_req;
    logic push;
    logic pop;
    logic advance;
    logic load_hold;
    logic valid;
    logic overflow;

    logic [Data_bits-1:0]   sample;
    logic [Index_width-1:0] out_idx;
    logic [Data_bits-1:0]   hold;
    state_t                 state;
    state_t                 state_n;

    logic [entry_width-1:0] head;
    logic                   head_last;
    logic                   head_tok;
    logic [Data_bits-1:0]   head_val;
    logic [Index_width-1:0] head_idx;

`ifdef LAVA_DECODER_ORDER_CHECK_EN
    logic err_set;
    logic error;
`endif

    assign full      = (count == full_count);
    assign empty     = (count == '0);
    assign push_req  = bus.token_valid_i | bus.frame_done_i;
    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push      = push_req & ~full;

    assign head      = mem[rd_ptr];
    assign head_last = head[entry_width-1];
    assign head_tok  = head[entry_width-2];
    assign head_val  = head[Index_width +: Data_bits];
    assign head_idx  = head[Index_width-1:0];

    // FIFO data write; payload storage carries no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {bus.frame_done_i, bus.token_valid_i, bus.token_i};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_width'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_width'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ptr_width + 1)'(1);
                2'b01:   count <= count - (ptr_width + 1)'(1);
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Next-state and output decode from FIFO head, state and hold value
    always_comb begin
        state_n   = state;
        valid     = 1'b0;
        sample    = hold;
        pop       = 1'b0;
        advance   = 1'b0;
        load_hold = 1'b0;
`ifdef LAVA_DECODER_ORDER_CHECK_EN
        err_set   = 1'b0;
`endif
        case (state)
            RUN: begin
                if (!empty) begin
                    if (!head_tok) begin
                        // Marker only: rest of the frame repeats hold.
                        valid = 1'b1;
                        if (bus.sample_ready_i) begin
                            pop     = 1'b1;
                            advance = 1'b1;
                            state_n = FLUSH;
                        end
                    end else if (head_idx == out_idx) begin
                        valid  = 1'b1;
                        sample = head_val;
                        if (bus.sample_ready_i) begin
                            pop       = 1'b1;
                            advance   = 1'b1;
                            load_hold = 1'b1;
                            if (head_last) begin
                                state_n = FLUSH;
                            end
                        end
                    end else begin
`ifdef LAVA_DECODER_ORDER_CHECK_EN
                        if (head_idx < out_idx) begin
                            // Stale token: drop it without emitting a beat.
                            pop     = 1'b1;
                            err_set = 1'b1;
                        end else begin
                            valid   = 1'b1;
                            advance = bus.sample_ready_i;
                        end
`else
                        // Token is ahead (or waits for next frame): hold.
                        valid   = 1'b1;
                        advance = bus.sample_ready_i;
`endif
                    end
                end
            end
            FLUSH: begin
                valid   = 1'b1;
                advance = bus.sample_ready_i;
            end
            default: state_n = RUN;
        endcase
        // End of frame always returns to RUN, overriding a FLUSH entry.
        if (advance && (out_idx == last_index)) begin
            state_n = RUN;
        end
    end

    // Output position counter, hold register and FSM state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RUN;
            out_idx <= '0;
            hold    <= '0;
        end else begin
            state <= state_n;
            if (advance) begin
                out_idx <= (out_idx == last_index) ? '0 : out_idx + Index_width'(1);
            end
            if (load_hold) begin
                hold <= head_val;
            end
        end
    end

`ifdef LAVA_DECODER_ORDER_CHECK_EN
    // Sticky out-of-order flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error <= 1'b0;
        end else if (err_set) begin
            error <= 1'b1;
        end
    end

    assign bus.error_o = error;
`else
    assign bus.error_o = 1'b0;
`endif

    assign bus.token_ready_o  = ~full;
    assign bus.sample_o       = sample;
    assign bus.sample_index_o = out_idx;
    assign bus.sample_valid_o = valid;
    assign bus.frame_last_o   = valid & (out_idx == last_index);
    assign bus.overflow_o     = overflow;
endmodule

// File: tb/tb_lava_decoder.sv
// Directed bench for lava_decoder with 8 samples per frame and a 4-entry FIFO.
module tb_lava_decoder;
    localparam int DB = 10;
    localparam int SPC = 8;
    localparam int FD = 4;
    localparam int IW = 3;

    typedef int frame_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    lava_decoder_if #(.Data_bits(DB), .Index_width(IW)) bus ();

    lava_decoder #(
        .Data_bits(DB),
        .Samples_per_channel(SPC),
        .Fifo_depth(FD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, int'(bus.sample_valid_o), 0);
        check({tag, " sample"}, int'(bus.sample_o), 0);
        check({tag, " index"}, int'(bus.sample_index_o), 0);
        check({tag, " last"}, int'(bus.frame_last_o), 0);
        check({tag, " ready"}, int'(bus.token_ready_o), 1);
        check({tag, " overflow"}, int'(bus.overflow_o), 0);
        check({tag, " error"}, int'(bus.error_o), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.token_valid_i = 1'b0;
        bus.frame_done_i = 1'b0;
        bus.sample_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle(tag);
    endtask

    task automatic push(input int val, input int idx, input logic fd);
        bus.token_i = {DB'(val), IW'(idx)};
        bus.token_valid_i = 1'b1;
        bus.frame_done_i = fd;
        tick();
        bus.token_valid_i = 1'b0;
        bus.frame_done_i = 1'b0;
    endtask

    task automatic marker();
        bus.frame_done_i = 1'b1;
        tick();
        bus.frame_done_i = 1'b0;
    endtask

    // Checks the beat on the bus, then consumes it (sample_ready_i high).
    task automatic expect_beat(input string tag, input int val, input int idx);
        check($sformatf("%s[%0d] valid", tag, idx), int'(bus.sample_valid_o), 1);
        check($sformatf("%s[%0d] sample", tag, idx), int'(bus.sample_o), val);
        check($sformatf("%s[%0d] index", tag, idx), int'(bus.sample_index_o), idx);
        check($sformatf("%s[%0d] last", tag, idx), int'(bus.frame_last_o), (idx == SPC - 1) ? 1 : 0);
        tick();
    endtask

    task automatic run_frame(input string tag, input frame_t v, input int first);
        for (int i = first; i < SPC; i++) begin
            expect_beat(tag, v[i], i);
        end
    endtask

    initial begin
        bus.token_i = '0;
        bus.token_valid_i = 1'b0;
        bus.frame_done_i = 1'b0;
        bus.sample_ready_i = 1'b0;

        // Basic frame: {20,0}, {50,3}, marker
        do_reset("rst1");
        push(20, 0, 1'b0);
        check("latency valid", int'(bus.sample_valid_o), 1);
        check("latency sample", int'(bus.sample_o), 20);
        push(50, 3, 1'b0);
        marker();
        bus.sample_ready_i = 1'b1;
        run_frame("basic", '{20, 20, 20, 50, 50, 50, 50, 50}, 0);
        check("basic drained", int'(bus.sample_valid_o), 0);

        // Marker-only frame after reset
        do_reset("rst2");
        marker();
        bus.sample_ready_i = 1'b1;
        run_frame("marker", '{0, 0, 0, 0, 0, 0, 0, 0}, 0);
        check("marker drained", int'(bus.sample_valid_o), 0);

        // Output stall for 5 cycles at index 2
        do_reset("rst3");
        push(20, 0, 1'b0);
        push(50, 3, 1'b0);
        marker();
        bus.sample_ready_i = 1'b1;
        expect_beat("stall", 20, 0);
        expect_beat("stall", 20, 1);
        bus.sample_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall hold%0d valid", i), int'(bus.sample_valid_o), 1);
            check($sformatf("stall hold%0d sample", i), int'(bus.sample_o), 20);
            check($sformatf("stall hold%0d index", i), int'(bus.sample_index_o), 2);
            tick();
        end
        bus.sample_ready_i = 1'b1;
        run_frame("stall", '{20, 20, 20, 50, 50, 50, 50, 50}, 2);
        check("stall drained", int'(bus.sample_valid_o), 0);

        // Overflow: five pushes into a 4-entry FIFO with output stalled
        do_reset("rst4");
        push(10, 0, 1'b0);
        push(11, 2, 1'b0);
        push(12, 4, 1'b0);
        check("ovf ready after 3", int'(bus.token_ready_o), 1);
        push(13, 6, 1'b0);
        check("ovf ready after 4", int'(bus.token_ready_o), 0);
        check("ovf flag after 4", int'(bus.overflow_o), 0);
        push(14, 7, 1'b0);
        check("ovf flag after 5", int'(bus.overflow_o), 1);
        check("ovf ready after 5", int'(bus.token_ready_o), 0);
        bus.sample_ready_i = 1'b1;
        expect_beat("ovf", 10, 0);
        bus.frame_done_i = 1'b1;
        expect_beat("ovf", 10, 1);
        bus.frame_done_i = 1'b0;
        run_frame("ovf", '{10, 10, 11, 11, 12, 12, 13, 13}, 2);
        check("ovf drained", int'(bus.sample_valid_o), 0);
        check("ovf sticky", int'(bus.overflow_o), 1);

        // Reset mid-frame discards FIFO and clears sticky flags
        bus.sample_ready_i = 1'b0;
        push(99, 3, 1'b0);
        do_reset("rst midframe");

        // Out-of-order token {40,2} behind {30,5}
        push(30, 5, 1'b0);
        push(40, 2, 1'b0);
        marker();
        bus.sample_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_beat("ooo", 0, i);
        end
        expect_beat("ooo", 30, 5);
`ifdef LAVA_DECODER_ORDER_CHECK_EN
        check("ooo discard valid", int'(bus.sample_valid_o), 0);
        check("ooo discard index", int'(bus.sample_index_o), 6);
        tick();
        check("ooo error", int'(bus.error_o), 1);
        expect_beat("ooo", 30, 6);
        expect_beat("ooo", 30, 7);
`else
        expect_beat("ooo", 30, 6);
        expect_beat("ooo", 30, 7);
        run_frame("ooo f2", '{30, 30, 40, 40, 40, 40, 40, 40}, 0);
        check("ooo error tied", int'(bus.error_o), 0);
`endif
        check("ooo drained", int'(bus.sample_valid_o), 0);

        // Token and frame_done together, then a marker-only frame
        do_reset("rst6");
        push(77, 7, 1'b1);
        marker();
        bus.sample_ready_i = 1'b1;
        run_frame("tokend f1", '{0, 0, 0, 0, 0, 0, 0, 77}, 0);
        run_frame("tokend f2", '{77, 77, 77, 77, 77, 77, 77, 77}, 0);
        check("tokend drained", int'(bus.sample_valid_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lava_decoder.md
# lava_decoder

Downstream reconstruction stage for the LAVA compressor. Accepts sparse `{value, index}` tokens emitted on threshold crossings and buffers them in a small FIFO. Regenerates the dense per-channel sample stream (one sample per index, sample-and-hold between tokens) on a ready/valid output. Used on the verification/readback side to rebuild channel data for comparison against uncompressed samples.

## Interface
- `Data_bits`, 10, sample width.
- `Samples_per_channel`, 3328, samples per channel frame; `Index_width = $clog2(Samples_per_channel)`.
- `Fifo_depth`, 8, token FIFO entries; power of two, at least 2.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `token_i`  in  `Data_bits+Index_width`  `{value, index}`, with value in the MSBs.
- `token_valid_i`  in  1  token present.
- `frame_done_i`  in  1  single-cycle pulse: all tokens of the current frame have been delivered.
- `token_ready_o`  out  1  FIFO not full.
- `sample_o`  out  `Data_bits`  reconstructed sample.
- `sample_index_o`  out  `Index_width`  index of `sample_o` within the frame.
- `sample_valid_o`  out  1  output beat valid.
- `sample_ready_i`  in  1  downstream accepts.
- `frame_last_o`  out  1  beat is index `Samples_per_channel-1`.
- `overflow_o`  out  1  sticky: a push was attempted while the FIFO was full.
- `error_o`  out  1  sticky: out-of-order token detected.

## Operation
- FIFO entry is `{last, has_tok, value, index}`.
- Push occurs on `token_valid_i | frame_done_i`:
  - `has_tok = token_valid_i`.
  - `last = frame_done_i`.
  - When both are high in the same cycle, the token belongs to the ending frame.
- A push while full drops the entry and sets `overflow_o`. Upstream ignoring `token_ready_o` is legal.
- Internal state:
  - `out_idx` counts 0..`Samples_per_channel-1`.
  - `hold` holds the sample value.
  - FSM has two states, `RUN` and `FLUSH`.
- State `RUN`:
  - FIFO empty: `sample_valid_o=0`.
  - Head `has_tok`, `index==out_idx`: present `value`. On handshake, `hold<=value`, pop, advance. If `last`, go to `FLUSH`.
  - Head `has_tok`, `index>out_idx`: present `hold`, advance, no pop.
  - Head `has_tok`, `index<out_idx`: out-of-order token; handling is per Configuration.
  - Head `!has_tok` (marker only): present `hold`. On handshake, pop, advance, go to `FLUSH`.
- State `FLUSH`:
  - Present `hold` every cycle without consulting the FIFO.
  - Advance on each handshake.
- Wrap:
  - A handshake at `out_idx==Samples_per_channel-1` sets `out_idx<=0` and state `<= RUN`.
  - This overrides any `FLUSH` transition in the same cycle.
- `hold` is not cleared at frame boundaries; it carries into the next frame.
- `sample_index_o = out_idx`.
- `frame_last_o = sample_valid_o & (out_idx==Samples_per_channel-1)`.
- A push and a pop in the same cycle are both performed; the occupancy count is unchanged.

## Timing
- Reset values:
  - `out_idx=0`, `hold=0`, state `RUN`, FIFO empty.
  - `token_ready_o=1`, `sample_valid_o=0`, `frame_last_o=0`.
  - `overflow_o=0`, `error_o=0`.
  - `sample_o=0`, `sample_index_o=0`.
- Reset asserted mid-frame discards FIFO contents and returns to these values next cycle.
- The FIFO is registered. Output signals are combinational from the FIFO head, the state and `hold`.
- Token latency: a token pushed into an empty FIFO in cycle N produces its beat in cycle N+1 at the earliest.
- `sample_valid_o` is not withdrawn while waiting for `sample_ready_i`.
- `sample_o` and `sample_index_o` stay stable while `sample_valid_o & !sample_ready_i`.
- Throughput: one sample per cycle while the FIFO is non-empty or the FSM is in `FLUSH`.
- `overflow_o` and `error_o` clear only on reset.

## Configuration
- `LAVA_DECODER_ORDER_CHECK_EN` defined:
  - A head token with `index<out_idx` is popped and discarded with no output beat that cycle.
  - `error_o` is set.
- Not defined:
  - `error_o` is tied 0.
  - A head token with `index<out_idx` is treated like `index>out_idx`; it waits and is applied when `out_idx` reaches its index in the following frame.

## Test plan
All scenarios use `Samples_per_channel=8`, `Fifo_depth=4`.
- Reset, then tokens `{20,0}`, `{50,3}`, then `frame_done_i`, `sample_ready_i=1` -> `sample_o` = 20,20,20,50,50,50,50,50; indices 0..7; `frame_last_o` only on index 7.
- Marker only (`frame_done_i` with no tokens) after reset -> eight beats of 0, then `sample_valid_o=0`.
- `sample_ready_i` low for 5 cycles mid-frame -> beat at index 2 held stable with values unchanged; sequence resumes with no skipped or repeated index.
- Push 5 tokens back-to-back with output stalled -> `token_ready_o=0` after the 4th push, 5th dropped, `overflow_o=1`. Frame reconstructs from the first 4 tokens.
- With the macro, tokens `{30,5}`, `{40,2}`, then `frame_done_i` -> `{40,2}` discarded, `error_o=1`, output 0×5, then 30×3.
- Token `{77,7}` with `frame_done_i` in the same cycle, then a second frame with marker only -> frame 1 ends at 77 on index 7; frame 2 outputs 77×8.
